// File: rtl/counter_step_checker_if.sv
// Observation bus from the up/down counter into its step checker: the sampled
// value, the direction that drove it, a valid strobe and the counter's reset.
interface counter_step_checker_if #(
  parameter int DATA_W = 4
);
  logic              sample_vld;
  logic [DATA_W-1:0] q_in;
  logic              up_in;
  logic              dut_rst;

  modport master (output sample_vld, q_in, up_in, dut_rst);
  modport slave  (input  sample_vld, q_in, up_in, dut_rst);
endinterface

// File: rtl/counter_step_checker.sv
// Receive-side monitor for a wrapping up/down counter: predicts each next value,
// tracks lock, flags illegal steps and counts overflow/underflow wraps.
module counter_step_checker #(
  parameter int DATA_W   = 4,
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 2
) (
  input  logic                clk,
  input  logic                reset,
  counter_step_checker_if.slave smp,
  input  logic                err_clr,
  input  logic                stat_clr,
  output logic                locked,
  output logic [DATA_W-1:0]   exp_q,
  output logic                err_pulse,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    wrap_up_cnt,
  output logic [CNT_W-1:0]    wrap_dn_cnt
);

  typedef enum logic [1:0] {UNSYNC, SYNCING, TRACK} state_t;

  localparam logic [3:0]        LOCK_RUN = 4'(LOCK_LEN);
  localparam logic [DATA_W-1:0] Q_MAX    = '1;

  state_t            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic              prev_up_q, prev_up_d;
  logic [DATA_W-1:0] exp_d;
  logic              match;
  logic              err_event;
  logic              wrap_up_event;
  logic              wrap_dn_event;

  // Saturating statistic update; a clear beats a simultaneous increment.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cur,
                                            input logic inc, input logic clr);
    if (clr)                         return '0;
    else if (inc && (cur != '1))     return cur + CNT_W'(1);
    else                             return cur;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    run_d         = run_q;
    prev_up_d     = prev_up_q;
    exp_d         = exp_q;
    match         = 1'b0;
    err_event     = 1'b0;
    wrap_up_event = 1'b0;
    wrap_dn_event = 1'b0;

    if (smp.dut_rst || !smp.sample_vld) begin
      // The counter free-runs or restarts, so any prediction is meaningless.
      state_d = UNSYNC;
      run_d   = '0;
    end else begin
      match     = (smp.q_in == exp_q);
      exp_d     = smp.up_in ? smp.q_in + DATA_W'(1) : smp.q_in - DATA_W'(1);
      prev_up_d = smp.up_in;
      unique case (state_q)
        UNSYNC: begin
          state_d = SYNCING;
          run_d   = '0;
        end
        SYNCING: begin
          if (match) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == LOCK_RUN) state_d = TRACK;
          end else begin
            run_d = '0;
          end
        end
        TRACK: begin
          if (match) begin
            // A matched step landing on 0 going up (or MAX going down) is a wrap.
            wrap_up_event = prev_up_q && (smp.q_in == '0);
            wrap_dn_event = !prev_up_q && (smp.q_in == Q_MAX);
          end else begin
            err_event = 1'b1;
            state_d   = SYNCING;
            run_d     = '0;
          end
        end
        default: state_d = UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= UNSYNC;
      run_q       <= '0;
      prev_up_q   <= 1'b0;
      exp_q       <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      err_cnt     <= '0;
      wrap_up_cnt <= '0;
      wrap_dn_cnt <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_up_q   <= prev_up_d;
      exp_q       <= exp_d;
      locked      <= (state_d == TRACK);
      err_pulse   <= err_event;
      err_sticky  <= err_event ? 1'b1 : (err_clr ? 1'b0 : err_sticky);
      err_cnt     <= bump(err_cnt, err_event, stat_clr);
      wrap_up_cnt <= bump(wrap_up_cnt, wrap_up_event, stat_clr);
      wrap_dn_cnt <= bump(wrap_dn_cnt, wrap_dn_event, stat_clr);
    end
  end

endmodule

// File: doc/counter_step_checker.md
Name: counter_step_checker

Overview:
- Receive-side monitor for the 4-bit up/down counter.
- Samples the counter output each cycle together with the direction/enable bit that drove it, and predicts the next value.
- Flags illegal steps, tracks lock, and counts overflow (15->0) and underflow (0->15) wrap events.
- Sits beside the counter in the DV/bring-up path. Fully synthesizable.

Parameters:
- DATA_W, 4, width of observed counter value.
- CNT_W, 8, width of the wrap and error statistic counters (saturating).
- LOCK_LEN, 2, consecutive consistent transitions required to assert locked (range 1..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_vld  input  1  q_in/up_in valid this cycle.
- q_in  input  DATA_W  observed counter value.
- up_in  input  1  direction applied in the same cycle as q_in: 1 = count up, 0 = count down.
- dut_rst  input  1  counter's reset is active this cycle; forces resync.
- err_clr  input  1  clears err_sticky.
- stat_clr  input  1  clears wrap_up_cnt, wrap_dn_cnt and err_cnt.
- locked  output  1  checker is tracking a consistent sequence.
- exp_q  output  DATA_W  predicted next q_in.
- err_pulse  output  1  one-cycle pulse on a step mismatch while locked.
- err_sticky  output  1  latched error.
- err_cnt  output  CNT_W  mismatch count.
- wrap_up_cnt  output  CNT_W  overflow count.
- wrap_dn_cnt  output  CNT_W  underflow count.

Behaviour:
- Reset (synchronous): state UNSYNC; all outputs 0; internal run counter 0.
- Prediction: exp = up_in ? q_in+1 : q_in-1, modulo 2^DATA_W. Captured on each valid sample; exp_q is registered.
- States:
  - UNSYNC -> SYNCING on a valid sample: capture exp, run = 0.
  - SYNCING, valid sample, q_in == exp_q: run++. When run reaches LOCK_LEN, go to TRACK and set locked = 1 next cycle.
  - SYNCING, valid sample, mismatch: recapture, run = 0. No error raised.
  - TRACK, valid sample, match: update exp_q, stay.
  - TRACK, valid sample, mismatch: err_pulse = 1 for one cycle, err_sticky = 1, err_cnt++. Then go to SYNCING, recapture from the observed sample with run = 0, and drop locked next cycle.
- Gaps: sample_vld = 0 in SYNCING or TRACK -> UNSYNC, locked = 0, no error (the counter free-runs, so the prediction is lost).
- dut_rst = 1 -> UNSYNC, locked = 0, no error; the sample is ignored.
- Priority: reset > dut_rst > sample_vld low > compare.
- Wrap counting applies only to matched transitions in TRACK:
  - prev 15, up, q_in = 0 -> wrap_up_cnt++.
  - prev 0, down, q_in = 15 -> wrap_dn_cnt++.
  - A valid up-step to 15 is not a wrap.
- Latency: err_pulse, counter updates and locked changes appear one cycle after the deciding sample edge.
- Statistics counters saturate at 2^CNT_W-1; they never roll over.
- stat_clr coinciding with an increment: the clear wins (result 0).
- err_clr coinciding with a new mismatch: the error wins (err_sticky stays 1).
- Direction change mid-stream (up_in toggles) is legal: the prediction follows the up_in sent with the previous sample.

Test Plan:
- Lock (LOCK_LEN = 2): after reset, samples (3,up), (4,up), (5,up) -> locked = 1 the cycle after sample 3; exp_q = 6; err_cnt = 0.
- Overflow: locked, samples (14,up), (15,up), (0,up), (1,down) -> wrap_up_cnt = 1, no error. Next sample 0 -> still locked, wrap_dn_cnt = 0.
- Underflow and direction toggle: locked, samples (1,down), (0,down), (15,up), (0,up) -> wrap_dn_cnt = 1, wrap_up_cnt += 1, no errors.
- Mismatch:
  - Locked expecting 7, present 9 -> err_pulse exactly one cycle, err_sticky = 1, err_cnt = 1, locked = 0.
  - Then (10,up), (11,up) -> relocks; err_sticky remains 1 until err_clr.
  - err_clr in the same cycle as a second mismatch -> err_sticky = 1, err_cnt = 2.
- Resync events:
  - dut_rst pulse while locked -> locked = 0 next cycle, no err_pulse.
  - sample_vld low for 1 cycle -> UNSYNC, no error.
  - Synchronous reset mid-TRACK -> all outputs 0 next cycle.
- Saturation (CNT_W = 2): five overflows -> wrap_up_cnt = 3.
  - stat_clr coincident with a sixth overflow -> wrap_up_cnt = 0.
